// File: rtl/mic_i2s_capture.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module      : mic_i2s_capture
//  Description : I2S bus master for a single MEMS microphone. Generates the
//                serial clock (sck) and word select (ws), deserialises the
//                left-channel slot into a D_WIDTH sample, and emits one
//                sample plus a one-clk strobe per frame. A start-up FSM
//                discards WARMUP_FRAMES settling frames after enable.
//
//  Parameters  : D_WIDTH       output sample width (1..SLOT_BITS-1)
//                SLOT_BITS     sck periods per channel slot
//                CLK_DIV       clk cycles per sck half-period (>= 2)
//                WARMUP_FRAMES complete frames discarded after enable
//
//  Ports       : clk          in   system clock
//                rst          in   asynchronous reset, active-low
//                en           in   capture enable; low forces IDLE
//                sd           in   serial data from microphone
//                sck          out  I2S serial clock (registered)
//                ws           out  I2S word select, 0 = left slot (registered)
//                mic_signal   out  last captured sample, held between strobes
//                sample_valid out  one-clk strobe, mic_signal updated
//                running      out  high while the FSM is in RUN
//
//  Build option: MIC_OFFSET_BINARY_EN - when defined, the sample MSB is
//                inverted before loading mic_signal (two's complement to
//                offset binary). Undefined: raw sample passed through.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module mic_i2s_capture #(
    parameter int D_WIDTH       = 8,
    parameter int SLOT_BITS     = 16,
    parameter int CLK_DIV       = 4,
    parameter int WARMUP_FRAMES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               sd,
    output logic               sck,
    output logic               ws,
    output logic [D_WIDTH-1:0] mic_signal,
    output logic               sample_valid,
    output logic               running
);

    localparam int c_DIV_W = $clog2(CLK_DIV);
    localparam int c_BIT_W = $clog2(SLOT_BITS);
    localparam int c_FRM_W = (WARMUP_FRAMES < 1) ? 1 : $clog2(WARMUP_FRAMES + 1);
    localparam int c_SH_W  = (D_WIDTH > 1) ? (D_WIDTH - 1) : 1;

    localparam logic [c_DIV_W-1:0] c_DIV_LAST   = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST   = c_BIT_W'(SLOT_BITS - 1);
    localparam logic [c_BIT_W-1:0] c_DATA_LAST  = c_BIT_W'(D_WIDTH);
    localparam logic [c_FRM_W-1:0] c_FRM_TARGET = c_FRM_W'(WARMUP_FRAMES);

`ifdef MIC_OFFSET_BINARY_EN
    // Inverting the MSB maps two's complement onto offset binary.
    localparam logic [D_WIDTH-1:0] c_OUT_XOR = D_WIDTH'(1) << (D_WIDTH - 1);
`else
    localparam logic [D_WIDTH-1:0] c_OUT_XOR = '0;
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WARMUP = 2'd1,
        S_RUN    = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [c_DIV_W-1:0]   div_q,   div_d;
    logic                 sck_q,   sck_d;
    logic                 ws_q,    ws_d;
    logic [c_BIT_W-1:0]   bit_q,   bit_d;
    logic [c_FRM_W-1:0]   frame_q, frame_d;
    logic [c_SH_W-1:0]    shift_q, shift_d;
    logic [D_WIDTH-1:0]   mic_q,   mic_d;
    logic                 valid_q, valid_d;
    logic                 run_q,   run_d;

    logic                 w_tick;
    logic                 w_rise;
    logic                 w_fall;
    logic                 w_in_data;
    logic [c_FRM_W-1:0]   w_frame_inc;
    logic [D_WIDTH-1:0]   w_word;
    logic [c_SH_W-1:0]    w_shift_next;

    // Divider terminal count: sck toggles on this edge. A rising sck edge is
    // the data-sampling point; a falling sck edge advances the bit counter.
    assign w_tick      = (div_q == c_DIV_LAST);
    assign w_rise      = w_tick & ~sck_q;
    assign w_fall      = w_tick & sck_q;
    assign w_frame_inc = frame_q + 1'b1;

    // Bit 0 of each slot is the I2S one-bit delay; only left-slot bits
    // 1..D_WIDTH carry sample data.
    assign w_in_data = ~ws_q && (bit_q != '0) && (bit_q <= c_DATA_LAST);

    // Word as it would look after shifting in the current sd bit.
    generate
        if (D_WIDTH == 1) begin : g_word_single
            assign w_word       = sd;
            assign w_shift_next = shift_q;
        end else begin : g_word_multi
            assign w_word       = {shift_q[D_WIDTH-2:0], sd};
            assign w_shift_next = w_word[D_WIDTH-2:0];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        sck_d   = sck_q;
        ws_d    = ws_q;
        bit_d   = bit_q;
        frame_d = frame_q;
        shift_d = shift_q;
        mic_d   = mic_q;
        valid_d = 1'b0;

        if (!en) begin
            // Abort: bus and counters clear at once, last sample is held.
            state_d = S_IDLE;
            div_d   = '0;
            sck_d   = 1'b0;
            ws_d    = 1'b0;
            bit_d   = '0;
            frame_d = '0;
            shift_d = '0;
        end else if (state_q == S_IDLE) begin
            state_d = (WARMUP_FRAMES == 0) ? S_RUN : S_WARMUP;
            div_d   = '0;
            sck_d   = 1'b0;
            ws_d    = 1'b0;
            bit_d   = '0;
            frame_d = '0;
            shift_d = '0;
        end else begin
            div_d = w_tick ? '0 : div_q + 1'b1;
            if (w_tick) begin
                sck_d = ~sck_q;
            end

            if (w_fall) begin
                if (bit_q == c_BIT_LAST) begin
                    bit_d = '0;
                    ws_d  = ~ws_q;
                    // ws going 1->0 closes a frame (right slot just ended).
                    if (ws_q) begin
                        if (frame_q != c_FRM_TARGET) begin
                            frame_d = w_frame_inc;
                        end
                        if ((state_q == S_WARMUP) && (w_frame_inc == c_FRM_TARGET)) begin
                            state_d = S_RUN;
                        end
                    end
                end else begin
                    bit_d = bit_q + 1'b1;
                end
            end

            if (w_rise && w_in_data) begin
                shift_d = w_shift_next;
                if ((bit_q == c_DATA_LAST) && (state_q == S_RUN)) begin
                    mic_d   = w_word ^ c_OUT_XOR;
                    valid_d = 1'b1;
                end
            end
        end

        run_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            sck_q   <= 1'b0;
            ws_q    <= 1'b0;
            bit_q   <= '0;
            frame_q <= '0;
            shift_q <= '0;
            mic_q   <= '0;
            valid_q <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            sck_q   <= sck_d;
            ws_q    <= ws_d;
            bit_q   <= bit_d;
            frame_q <= frame_d;
            shift_q <= shift_d;
            mic_q   <= mic_d;
            valid_q <= valid_d;
            run_q   <= run_d;
        end
    end

    assign sck          = sck_q;
    assign ws           = ws_q;
    assign mic_signal   = mic_q;
    assign sample_valid = valid_q;
    assign running      = run_q;

endmodule
`default_nettype wire

// File: tb/tb_mic_i2s_capture.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mic_i2s_capture
//  Description : Self-checking bench for mic_i2s_capture. Two instances:
//                default parameters, and WARMUP_FRAMES=0. A behavioural
//                microphone drives sd from a per-frame word table, counting
//                sck falls since enable; expected samples and strobe edges
//                come from frame arithmetic.
//  Ports       : none
//  Build option: MIC_OFFSET_BINARY_EN selects offset-binary expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mic_i2s_capture;

    logic       clk = 1'b0;
    logic       rst, en, en0, sd, sd0;
    logic       sck, ws, sv, running;
    logic       sck0, ws0, sv0, running0;
    logic [7:0] mic, mic0;

    int         cyc = 0;
    int         base = 0;
    int         passed = 0;
    int         total = 0;
    logic [7:0] left_words [64];
    logic [7:0] right_word;
    logic [7:0] last_exp;

    int         mcnt = 0, mcnt0 = 0;
    logic       mprev = 1'b0, mprev0 = 1'b0;

    mic_i2s_capture dut (
        .clk(clk), .rst(rst), .en(en), .sd(sd),
        .sck(sck), .ws(ws), .mic_signal(mic),
        .sample_valid(sv), .running(running)
    );

    mic_i2s_capture #(.WARMUP_FRAMES(0)) dut0 (
        .clk(clk), .rst(rst), .en(en0), .sd(sd0),
        .sck(sck0), .ws(ws0), .mic_signal(mic0),
        .sample_valid(sv0), .running(running0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] xf(input logic [7:0] w);
`ifdef MIC_OFFSET_BINARY_EN
        return w ^ 8'h80;
`else
        return w;
`endif
    endfunction

    // Microphone: after the n-th sck fall since enable it presents frame
    // position n mod 32. Left bits 1..8 carry the frame word MSB first,
    // right bits 1..8 carry right_word; every other position is junk.
    function automatic logic sd_bit(input int n);
        int         pos, f, k;
        logic [7:0] w;
        pos = n % 32;
        f   = (n / 32) % 64;
        if (pos < 16) begin
            k = pos;
            w = left_words[f];
        end else begin
            k = pos - 16;
            w = right_word;
        end
        if (k >= 1 && k <= 8) return w[8-k];
        return 1'($urandom);
    endfunction

    always @(negedge clk) begin : mic_model
        int n;
        n = mcnt;
        if (!en) begin
            n = 0;
            mprev <= 1'b0;
        end else begin
            if (mprev && !sck) n = n + 1;
            mprev <= sck;
        end
        mcnt <= n;
        sd   <= sd_bit(n);
    end

    always @(negedge clk) begin : mic_model0
        int n;
        n = mcnt0;
        if (!en0) begin
            n = 0;
            mprev0 <= 1'b0;
        end else begin
            if (mprev0 && !sck0) n = n + 1;
            mprev0 <= sck0;
        end
        mcnt0 <= n;
        sd0   <= sd_bit(n);
    end

    // Raise enable so the next posedge is edge index 0.
    task automatic start_en(input bit which);
        @(negedge clk);
        if (which) en0 = 1'b1;
        else       en  = 1'b1;
        base = cyc + 1;
    endtask

    task automatic stop_en();
        @(negedge clk);
        en  = 1'b0;
        en0 = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Returns edge index of the next strobe, or -1 when the budget expires.
    task automatic wait_strobe(input bit which, input int budget, output int at);
        at = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (which ? sv0 : sv) begin
                at = cyc - base;
                break;
            end
        end
    endtask

    task automatic fill_words(input bit rnd, input logic [7:0] fixed);
        for (int i = 0; i < 64; i++)
            left_words[i] = rnd ? 8'($urandom_range(1, 255)) : fixed;
    endtask

    task automatic test_reset();
        #12;
        total++; if (sck !== 1'b0) $display("FAIL reset_sck: got %b expected 0", sck); else passed++;
        total++; if (ws !== 1'b0) $display("FAIL reset_ws: got %b expected 0", ws); else passed++;
        total++; if (sv !== 1'b0) $display("FAIL reset_valid: got %b expected 0", sv); else passed++;
        total++; if (running !== 1'b0) $display("FAIL reset_running: got %b expected 0", running); else passed++;
        total++; if (mic !== 8'h00) $display("FAIL reset_mic: got %h expected 00", mic); else passed++;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_capture();
        int t;
        fill_words(1'b0, 8'hA5);
        right_word = 8'hFF;
        start_en(1'b0);
        wait_strobe(1'b0, 700, t);
        total++; if (t !== 580) $display("FAIL capture_first_edge: got %0d expected 580", t); else passed++;
        total++; if (mic !== xf(8'hA5)) $display("FAIL capture_value: got %h expected %h", mic, xf(8'hA5)); else passed++;
        total++; if (running !== 1'b1) $display("FAIL capture_running: got %b expected 1", running); else passed++;
        @(negedge clk);
        total++; if (sv !== 1'b0) $display("FAIL capture_strobe_width: got %b expected 0", sv); else passed++;
        wait_strobe(1'b0, 300, t);
        total++; if (t !== 836) $display("FAIL capture_second_edge: got %0d expected 836", t); else passed++;
        last_exp = xf(8'hA5);
        stop_en();
    endtask

    task automatic test_right_only();
        int t;
        fill_words(1'b0, 8'h00);
        right_word = 8'hFF;
        start_en(1'b0);
        for (int i = 0; i < 2; i++) begin
            wait_strobe(1'b0, 700, t);
            total++;
            if (t !== 580 + 256 * i || mic !== xf(8'h00))
                $display("FAIL right_only_%0d: got edge %0d value %h expected edge %0d value %h",
                         i, t, mic, 580 + 256 * i, xf(8'h00));
            else passed++;
        end
        last_exp = xf(8'h00);
        stop_en();
    endtask

    task automatic test_no_warmup();
        int t;
        fill_words(1'b0, 8'h3C);
        right_word = 8'($urandom);
        start_en(1'b1);
        @(negedge clk);
        total++; if (running0 !== 1'b1) $display("FAIL nowarm_running_e0: got %b expected 1", running0); else passed++;
        wait_strobe(1'b1, 200, t);
        total++; if (t !== 68) $display("FAIL nowarm_first_edge: got %0d expected 68", t); else passed++;
        total++; if (mic0 !== xf(8'h3C)) $display("FAIL nowarm_value: got %h expected %h", mic0, xf(8'h3C)); else passed++;
        stop_en();
    endtask

    task automatic test_random();
        int t;
        fill_words(1'b1, 8'h00);
        right_word = 8'($urandom);
        start_en(1'b0);
        for (int i = 0; i < 4; i++) begin
            wait_strobe(1'b0, 700, t);
            total++; if (t !== 580 + 256 * i) $display("FAIL random_edge_%0d: got %0d expected %0d", i, t, 580 + 256 * i); else passed++;
            total++; if (mic !== xf(left_words[2+i])) $display("FAIL random_value_%0d: got %h expected %h", i, mic, xf(left_words[2+i])); else passed++;
        end
        last_exp = xf(left_words[5]);
        stop_en();
    endtask

    task automatic test_en_drop();
        int   idx, t;
        logic held_ok;
        logic [7:0] held;
        held    = last_exp;
        held_ok = 1'b1;
        t       = -1;
        fill_words(1'b1, 8'h00);
        right_word = 8'($urandom);
        start_en(1'b0);
        for (int k = 0; k < 1100; k++) begin
            @(negedge clk);
            idx = cyc - base;
            if (sv) begin
                t = idx;
                break;
            end
            if (mic !== held) held_ok = 1'b0;
            if (idx == 100) begin
                total++; if (running !== 1'b0) $display("FAIL drop_warmup_running: got %b expected 0", running); else passed++;
            end
            if (idx == 299) en = 1'b0;
            if (idx == 300) begin
                total++; if (sck !== 1'b0) $display("FAIL drop_sck: got %b expected 0", sck); else passed++;
                total++; if (ws !== 1'b0) $display("FAIL drop_ws: got %b expected 0", ws); else passed++;
                total++; if (running !== 1'b0) $display("FAIL drop_running: got %b expected 0", running); else passed++;
            end
            if (idx == 399) en = 1'b1;
        end
        total++; if (held_ok !== 1'b1) $display("FAIL drop_mic_hold: got changed expected held %h", held); else passed++;
        total++; if (t !== 980) $display("FAIL drop_restart_edge: got %0d expected 980", t); else passed++;
        total++; if (mic !== xf(left_words[2])) $display("FAIL drop_restart_value: got %h expected %h", mic, xf(left_words[2])); else passed++;
        stop_en();
    endtask

    task automatic test_ws_sck();
        logic psck, pws;
        int   toggles, first, rises, bad;
        psck = 1'b0; pws = 1'b0;
        toggles = 0; first = -1; rises = 0; bad = 0;
        fill_words(1'b1, 8'h00);
        start_en(1'b0);
        for (int k = 0; k < 800; k++) begin
            @(negedge clk);
            if (ws !== pws) begin
                if (first < 0) first = cyc - base;
                toggles++;
                if (!(psck === 1'b1 && sck === 1'b0)) bad++;
                if (rises != 16) bad++;
                rises = 0;
            end
            if (psck === 1'b0 && sck === 1'b1) rises++;
            psck = sck;
            pws  = ws;
        end
        total++; if (bad !== 0) $display("FAIL wssck_alignment: got %0d violations expected 0", bad); else passed++;
        total++; if (toggles !== 6) $display("FAIL wssck_toggles: got %0d expected 6", toggles); else passed++;
        total++; if (first !== 128) $display("FAIL wssck_first_toggle: got %0d expected 128", first); else passed++;
        stop_en();
    endtask

    task automatic test_reset_midrun();
        int   t, idx;
        logic zero_ok;
        fill_words(1'b1, 8'h00);
        right_word = 8'($urandom);
        start_en(1'b0);
        for (int k = 0; k < 800; k++) begin
            @(negedge clk);
            if (cyc - base == 700) break;
        end
        // Between edges, with sck and ws both high after E700.
        #1;
        rst = 1'b0;
        en  = 1'b0;
        #1;
        total++; if (sck !== 1'b0) $display("FAIL midrst_sck: got %b expected 0", sck); else passed++;
        total++; if (ws !== 1'b0) $display("FAIL midrst_ws: got %b expected 0", ws); else passed++;
        total++; if (sv !== 1'b0) $display("FAIL midrst_valid: got %b expected 0", sv); else passed++;
        total++; if (running !== 1'b0) $display("FAIL midrst_running: got %b expected 0", running); else passed++;
        total++; if (mic !== 8'h00) $display("FAIL midrst_mic: got %h expected 00", mic); else passed++;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        fill_words(1'b1, 8'h00);
        start_en(1'b0);
        zero_ok = 1'b1;
        t = -1;
        for (int k = 0; k < 700; k++) begin
            @(negedge clk);
            idx = cyc - base;
            if (sv) begin
                t = idx;
                break;
            end
            if (mic !== 8'h00) zero_ok = 1'b0;
        end
        total++; if (zero_ok !== 1'b1) $display("FAIL midrst_mic_zero: got nonzero expected 00"); else passed++;
        total++; if (t !== 580) $display("FAIL midrst_first_edge: got %0d expected 580", t); else passed++;
        total++; if (mic !== xf(left_words[2])) $display("FAIL midrst_value: got %h expected %h", mic, xf(left_words[2])); else passed++;
        stop_en();
    endtask

    initial begin
        rst = 1'b0;
        en  = 1'b0;
        en0 = 1'b0;
        right_word = 8'h00;
        last_exp   = 8'h00;
        fill_words(1'b0, 8'h00);
        test_reset();
        test_capture();
        test_right_only();
        test_no_warmup();
        test_random();
        test_en_drop();
        test_ws_sck();
        test_reset_midrun();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, %0d/%0d done", passed, total);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/mic_i2s_capture.md
Name: mic_i2s_capture

Overview:
- Upstream stage of the signal-delay path. Acts as I2S bus master for a single MEMS microphone.
  - Generates the serial clock (sck) and word-select (ws).
  - Deserialises the left-channel slot into a parallel D_WIDTH sample.
- Emits one sample plus a one-cycle strobe per frame. The strobe drives the delay stage's write enable; the sample drives its mic_signal input.
- A start-up FSM discards the microphone's settling frames before any sample is emitted.

Parameters:
- D_WIDTH, 8: output sample width. Legal range 1..SLOT_BITS-1.
- SLOT_BITS, 16: sck periods per channel slot. One frame = 2*SLOT_BITS sck periods.
- CLK_DIV, 4: clk cycles per sck half-period. Must be >= 2.
- WARMUP_FRAMES, 2: complete frames discarded after enable. 0 means emit from the first frame.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-low
- en  input  1  capture enable; low forces IDLE
- sd  input  1  serial data from microphone
- sck  output  1  I2S serial clock, registered
- ws  output  1  I2S word select, registered; 0 = left slot
- mic_signal  output  D_WIDTH  last captured sample, held between strobes
- sample_valid  output  1  one-clk strobe: mic_signal updated this cycle
- running  output  1  high while FSM is in RUN

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; sck=0, ws=0, mic_signal=0, sample_valid=0, running=0; all counters cleared.
- FSM states: IDLE, WARMUP, RUN.
  - IDLE -> WARMUP when en=1 and WARMUP_FRAMES>0.
  - IDLE -> RUN when en=1 and WARMUP_FRAMES=0.
  - WARMUP -> RUN at the frame boundary at which frame_cnt reaches WARMUP_FRAMES.
  - Any state -> IDLE on the edge where en=0. sck, ws and counters clear immediately; mic_signal is held.
- Leaving IDLE at clk edge E0: div_cnt=0, sck=0, bit_cnt=0, ws=0.
- Clock divider:
  - div_cnt increments each clk outside IDLE.
  - When div_cnt==CLK_DIV-1, div_cnt<=0 and sck toggles.
  - Rising sck edge n (0-based) therefore occurs at E_{CLK_DIV*(2n+1)}.
- Slot and frame sequencing:
  - On each sck 1->0 transition, bit_cnt increments.
  - When bit_cnt==SLOT_BITS-1 it wraps to 0 and ws toggles, so ws changes coincident with sck falling.
  - A ws 1->0 toggle marks a frame boundary; frame_cnt increments there, saturating at WARMUP_FRAMES.
- Data capture:
  - sd is sampled on the clk edge at which sck transitions 0->1.
  - I2S one-bit delay: bit_cnt=0 of every slot is ignored.
  - In the left slot (ws=0), bits at bit_cnt 1..D_WIDTH are shifted in MSB first.
  - Right slot and bit_cnt > D_WIDTH are ignored.
- Output:
  - On the capture edge with ws=0 and bit_cnt==D_WIDTH, while in RUN, mic_signal <= {shift[D_WIDTH-2:0], sd} (after the optional transform) and sample_valid <= 1 for exactly one clk.
  - No strobe is issued in WARMUP or IDLE.
- Rate: one strobe per 4*SLOT_BITS*CLK_DIV clk. Default: every 256 clk.
- en dropping mid-slot discards the partial sample; re-enable restarts with a full warm-up.
- running = (state==RUN), registered with the state.

Optional Feature:
- Macro: MIC_OFFSET_BINARY_EN.
- Defined: captured word has its MSB inverted before loading mic_signal, converting two's complement to offset binary (0x00 -> 0x80, 0x80 -> 0x00) for unsigned downstream plotting.
- Undefined: raw two's-complement word is passed through unchanged.

Test Plan:
- Reset with rst=0 mid-run (default params) -> sck, ws, sample_valid, running and mic_signal read 0 asynchronously; mic_signal stays 0 until the first strobe.
- en=1 at E0, sd model drives left data 0xA5 MSB first (driven after each sck fall), right slot 0xFF:
  - first sample_valid set at E580;
  - mic_signal=0xA5 (0x25 with MIC_OFFSET_BINARY_EN);
  - next strobe exactly 256 clk later.
- WARMUP_FRAMES=0, left data 0x3C -> first strobe set at E68 with mic_signal=0x3C; running high from E0.
- Right-slot-only activity (left 0x00, right 0xFF) -> mic_signal=0x00 (0x80 with macro); right data never leaks into mic_signal.
- en dropped at E300 then re-raised at E400 -> sck/ws return to 0 at E300, no strobe before E980 (E400 + 580), mic_signal holds its previous value throughout.
- ws/sck relation -> ws only toggles on sck falling edges, every 16 sck periods; exactly 8 data captures per left slot.
